// File: rtl/addsub_seq.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, N = WIDTH/CHUNK cycles.
// Define ADDSUB_STICKY_OVF_EN to build the sticky overflow register.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             CarryOUT,
    output logic             overflow,
    output logic             opError,
    input  logic             clear,
    output logic             ovfSticky
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q, y_acc;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             op_ok;
    logic             a_msb, b_msb;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] y_nxt, a_rot, b_rot;
    logic             last, ovf_nxt;

    // Operands rotate so chunk i is always in the low bits; after N
    // rotations a_q is back to the original A.
    assign csum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                 + (CHUNK+1)'(carry);
    assign a_rot = (a_q >> CHUNK) | (a_q << (WIDTH - CHUNK));
    assign b_rot = (b_q >> CHUNK) | (b_q << (WIDTH - CHUNK));
    assign y_nxt = (y_acc >> CHUNK)
                 | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign last    = (idx == IW'(N - 1));
    assign ovf_nxt = op_ok & (a_msb == b_msb) & (y_nxt[WIDTH-1] != a_msb);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            y_acc    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            op_ok    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Y        <= '0;
            CarryOUT <= 1'b0;
            overflow <= 1'b0;
            opError  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= (opCode == 2'b10) ? ~B : B;
                        a_msb <= A[WIDTH-1];
                        b_msb <= (opCode == 2'b10) ? ~B[WIDTH-1]
                                                   : B[WIDTH-1];
                        carry <= CarryIN;
                        op_ok <= (opCode == 2'b01) || (opCode == 2'b10);
                        idx   <= '0;
                        y_acc <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_rot;
                    b_q   <= b_rot;
                    y_acc <= y_nxt;
                    carry <= csum[CHUNK];
                    idx   <= idx + IW'(1);
                    if (last) begin
                        Y        <= op_ok ? y_nxt : a_rot;
                        CarryOUT <= op_ok & csum[CHUNK];
                        overflow <= ovf_nxt;
                        opError  <= ~op_ok;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDSUB_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (reset)                                sticky_q <= 1'b0;
        else if (state == RUN && last && ovf_nxt) sticky_q <= 1'b1;
        else if (clear)                           sticky_q <= 1'b0;
    end

    assign ovfSticky = sticky_q;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign ovfSticky    = 1'b0;
`endif

endmodule
